// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared load/store size, state and extension encodings
package mem_pkg;

    // Size encoding matches funct3[1:0] of the load/store instructions.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } dmem_state_t;

    // req_unsigned mirrors funct3[2]: high selects zero extension.
    localparam logic LOAD_ZERO_EXT = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables and write replication for stores, lane extraction and extension for loads
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [15:0] shifted;
    logic        sext;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = '0;
        shifted = 16'(rdata_i >> {lane_i, 3'b000});
        sext    = (unsigned_i != LOAD_ZERO_EXT);
        case (mem_size_t'(size_i))
            BYTE: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            WORD: begin
                be_o    = 4'b1111;
                rdata_o = rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data-memory target with fixed access latency
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic        busy_o
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    dmem_state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    mem_size_t   size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata_sh;
    logic [31:0]   rdata_ext;
    logic          misaligned;
    logic          out_of_range;
    logic          access_err;
    logic          commit;

    assign idx          = addr_q[AW+1:2];
    assign misaligned   = ((size_q == HALF) && addr_q[0]) ||
                          ((size_q == WORD) && (addr_q[1:0] != 2'b00));
    assign out_of_range = (addr_q[31:2] >= 30'(DEPTH));
    assign access_err   = misaligned || out_of_range || (size_q == RSVD);
    // The access happens on the edge that leaves ACCESS for RESP.
    assign commit       = (state_q == ACCESS) && (cnt_q == 3'd0);

    mem_lane_align u_align (
        .size_i     (size_q),
        .lane_i     (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_q[idx]),
        .be_o       (be),
        .wdata_o    (wdata_sh),
        .rdata_o    (rdata_ext)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_INIT;
                    write_d = req_write_i;
                    size_d  = mem_size_t'(req_size_i);
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                end
            end
            ACCESS: begin
                if (cnt_q == 3'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = access_err;
                    resp_rdata_d = (!write_q && !access_err) ? rdata_ext : '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            write_q      <= 1'b0;
            size_q       <= BYTE;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk_i) begin
        if (commit && write_q && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
                end
            end
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_error_o = resp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed and randomized checks of data_mem_responder
module tb_data_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid, req_valid3;
    logic        req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_error, busy;
    logic [31:0] resp_rdata;
    logic        ready3, rvalid3, rerr3, busy3;
    logic [31:0] rdata3;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] rd_v;
    logic        er_v;
    int          lat_v;

    always #5 clk_i = ~clk_i;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(resp_valid),
        .resp_rdata_o(resp_rdata), .resp_error_o(resp_error), .busy_o(busy)
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(3)) dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid3), .req_ready_o(ready3),
        .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(rvalid3),
        .resp_rdata_o(rdata3), .resp_error_o(rerr3), .busy_o(busy3)
    );

    task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk_i);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        lat_v = -1; rd_v = '0; er_v = 1'b0;
        @(negedge clk_i);
        req_valid = 1'b0;
        for (int n = 1; n <= 8 && lat_v < 0; n++) begin
            if (n > 1) @(negedge clk_i);
            if (resp_valid) begin
                lat_v = n; rd_v = resp_rdata; er_v = resp_error;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_valid = 1'b1; req_valid3 = 1'b0;
        req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk_i);
        total++;
        if ({req_ready, busy, resp_valid, resp_error, resp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b busy=%b v=%b e=%b d=%h exp rdy=1 busy=0 v=0 e=0 d=0",
                     req_ready, busy, resp_valid, resp_error, resp_rdata);
        end
        req_valid = 1'b0;
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_loads();
        string       nm  [4] = '{"lb13", "lbu13", "lh12", "lhu10"};
        logic [1:0]  szv [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        uv  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] av  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] ev  [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        total++;
        if (er_v !== 1'b0 || lat_v !== 3) begin
            bad++; $display("FAIL sw10 got err=%b lat=%0d exp err=0 lat=3", er_v, lat_v);
        end
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, szv[i], uv[i], av[i], 32'h0);
            total++;
            if (rd_v !== ev[i] || er_v !== 1'b0 || lat_v !== 3) begin
                bad++;
                $display("FAIL %s got d=%h err=%b lat=%0d exp d=%h err=0 lat=3", nm[i], rd_v, er_v, lat_v, ev[i]);
            end
        end
    endtask

    task automatic test_store_merge();
        xact(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FF55);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        total++;
        if (rd_v !== 32'hDEAD_55EF || er_v !== 1'b0) begin
            bad++; $display("FAIL sb_merge got d=%h err=%b exp d=deed55ef-> dead55ef err=0", rd_v, er_v);
        end
        xact(1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD_1234);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        total++;
        if (rd_v !== 32'h1234_55EF || er_v !== 1'b0) begin
            bad++; $display("FAIL sh_merge got d=%h err=%b exp d=123455ef err=0", rd_v, er_v);
        end
    endtask

    task automatic test_errors();
        string       nm  [6] = '{"lw_misal", "sw_oor", "lw0_after_oor", "rsvd_size", "sh_misal", "lw0_after_sh"};
        logic        wv  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  szv [6] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd1, 2'd2};
        logic [31:0] av  [6] = '{32'h11, 32'h400, 32'h0, 32'h0, 32'h1, 32'h0};
        logic [31:0] wdv [6] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_7777, 32'h0};
        logic [31:0] ed  [6] = '{32'h0, 32'h0, 32'h0BAD_CAFE, 32'h0, 32'h0, 32'h0BAD_CAFE};
        logic        ee  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        xact(1'b1, 2'd2, 1'b0, 32'h0, 32'h0BAD_CAFE);
        for (int i = 0; i < 6; i++) begin
            xact(wv[i], szv[i], 1'b0, av[i], wdv[i]);
            total++;
            if (rd_v !== ed[i] || er_v !== ee[i] || lat_v !== 3) begin
                bad++;
                $display("FAIL %s got d=%h err=%b lat=%0d exp d=%h err=%b lat=3", nm[i], rd_v, er_v, lat_v, ed[i], ee[i]);
            end
        end
    endtask

    task automatic test_latency3();
        @(negedge clk_i);
        req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h400; req_wdata = '0;
        req_valid3 = 1'b1;
        total++;
        if (ready3 !== 1'b1) begin
            bad++; $display("FAIL lat3_c0_ready got=%b exp=1", ready3);
        end
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk_i);
            total++;
            if (rvalid3 !== (n == 4) || ready3 !== (n == 5) || busy3 !== (n != 5)) begin
                bad++;
                $display("FAIL lat3_c%0d got v=%b rdy=%b busy=%b exp v=%b rdy=%b busy=%b",
                         n, rvalid3, ready3, busy3, (n == 4), (n == 5), (n != 5));
            end
            if (n == 4) begin
                total++;
                if (rdata3 !== 32'h0 || rerr3 !== 1'b1) begin
                    bad++; $display("FAIL lat3_resp got d=%h err=%b exp d=0 err=1", rdata3, rerr3);
                end
            end
        end
        req_valid3 = 1'b0;
        repeat (6) @(negedge clk_i);
    endtask

    task automatic test_reset_midflight();
        logic seen;
        xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h1111_2222);
        @(negedge clk_i);
        req_write = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
        req_valid = 1'b1;
        @(negedge clk_i);
        req_valid = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        total++;
        if ({req_ready, busy, resp_valid, resp_error, resp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL rst_access_outputs got rdy=%b busy=%b v=%b e=%b d=%h exp rdy=1 busy=0 v=0 e=0 d=0",
                     req_ready, busy, resp_valid, resp_error, resp_rdata);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            seen |= resp_valid;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL rst_access_noresp got v=%b exp=0", seen);
        end
        xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        total++;
        if (rd_v !== 32'h1111_2222 || er_v !== 1'b0) begin
            bad++; $display("FAIL rst_access_nostore got d=%h err=%b exp d=11112222 err=0", rd_v, er_v);
        end
        // Reset landing in RESP: store already committed, pulse cut.
        @(negedge clk_i);
        req_write = 1'b1; req_size = 2'd2; req_addr = 32'h24; req_wdata = 32'hA5A5_5A5A;
        req_valid = 1'b1;
        @(negedge clk_i);
        req_valid = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("FAIL rst_resp_cut got v=%b exp=0", resp_valid);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        xact(1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
        total++;
        if (rd_v !== 32'hA5A5_5A5A || er_v !== 1'b0) begin
            bad++; $display("FAIL rst_resp_committed got d=%h err=%b exp d=a5a55a5a err=0", rd_v, er_v);
        end
    endtask

    task automatic test_random();
        logic [31:0] model [16];
        logic [31:0] a, wd, ed, word;
        logic [1:0]  sz;
        logic        w, u, ee;
        logic [7:0]  b;
        logic [15:0] h;
        int          sel;
        for (int i = 0; i < 16; i++) begin
            model[i] = 32'h1357_9BDF ^ (32'h0101_0101 * i);
            xact(1'b1, 2'd2, 1'b0, 32'(i * 4), model[i]);
        end
        for (int k = 0; k < 2000; k++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0)      a = 32'h400 + 32'($urandom_range(0, 255));
            else if (sel == 1) a = $urandom | 32'h8000_0000;
            else               a = 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            wd = $urandom;
            ee = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (a >= 32'h400);
            ed = '0;
            if (!ee) begin
                word = model[a[5:2]];
                if (w) begin
                    case (sz)
                        2'd0:    word[a[1:0]*8 +: 8] = wd[7:0];
                        2'd1:    word[a[1]*16 +: 16] = wd[15:0];
                        default: word = wd;
                    endcase
                    model[a[5:2]] = word;
                end else begin
                    b = word[a[1:0]*8 +: 8];
                    h = word[a[1]*16 +: 16];
                    case (sz)
                        2'd0:    ed = u ? {24'h0, b} : {{24{b[7]}}, b};
                        2'd1:    ed = u ? {16'h0, h} : {{16{h[15]}}, h};
                        default: ed = word;
                    endcase
                end
            end
            xact(w, sz, u, a, wd);
            total++;
            if (rd_v !== ed || er_v !== ee || lat_v !== 3) begin
                bad++;
                $display("FAIL rand%0d w=%b sz=%0d u=%b a=%h got d=%h err=%b lat=%0d exp d=%h err=%b lat=3",
                         k, w, sz, u, a, rd_v, er_v, lat_v, ed, ee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_merge();
        test_errors();
        test_latency3();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
